ti_psg_ctrl: RTL and testbench

- Register-file and tone/noise sequencer for the SN76489-style PSG.
- Accepts byte writes from the CPU bus over a valid/ready handshake and decodes the latch/data protocol into four volume registers, three 10-bit tone registers and one noise control register.
- Runs the tone counters and the noise LFSR, and drives vol0..vol3 and ch0out..ch3out straight into ti_mixer.

---
 rtl/ti_psg_ctrl_if.sv | 9 +
 rtl/ti_psg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ti_psg_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ti_psg_ctrl_if.sv
// CPU write port of the PSG: one byte per valid/ready handshake.
interface ti_psg_ctrl_if;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;

   modport master (output wr_valid, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/ti_psg_ctrl.sv
// SN76489-style PSG register file plus tone/noise sequencer feeding ti_mixer.
// One tone channel: square wave whose half-period is the tone register in ticks.
module ti_psg_tone (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       tick,
   input  logic [9:0] period,
   output logic       out
);
   logic [9:0] cnt;

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (tick) begin
         if (period <= 10'd1) begin
            cnt <= '0;
            out <= 1'b1;
         end else if (cnt != '0) begin
            cnt <= cnt - 10'd1;
         end else begin
            cnt <= period - 10'd1;
            out <= ~out;
         end
      end
endmodule

module ti_psg_ctrl #(
   parameter int DIV     = 16,
   parameter int WR_HOLD = 2,
   parameter int LFSR_W  = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   ti_psg_ctrl_if.slave wr,
   output logic [3:0]   vol0,
   output logic [3:0]   vol1,
   output logic [3:0]   vol2,
   output logic [3:0]   vol3,
   output logic         ch0out,
   output logic         ch1out,
   output logic         ch2out,
   output logic         ch3out
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HW = (WR_HOLD > 0) ? $clog2(WR_HOLD + 1) : 1;
   localparam logic [LFSR_W-1:0] LFSR_RST = {1'b1, {(LFSR_W-1){1'b0}}};

   logic [PW-1:0]       pre;
   logic                tick;
   logic [HW-1:0]       hold;
   logic                accept;
   logic [3:0][3:0]     vol_r;
   logic [2:0][9:0]     tone;
   logic [2:0]          noise;
   logic [1:0]          lch;
   logic                ltype;
   logic                is_latch, tgt_vol, tone_we, noise_we;
   logic [1:0]          tgt_ch;
   logic [2:0]          ch_out;
   logic [9:0]          ncnt, ncnt_next, nper;
   logic                nff, nff_next, shift, fb;
   logic [LFSR_W-1:0]   lfsr;

   // Prescaler
   assign tick = (pre == PW'(DIV - 1));

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST)     pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + PW'(1);

   // Write handshake: ready drops for WR_HOLD cycles after each accepted byte
   assign wr.wr_ready = (hold == '0);
   assign accept      = wr.wr_valid && wr.wr_ready;

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST)              hold <= '0;
      else if (accept)        hold <= HW'(WR_HOLD);
      else if (hold != '0)    hold <= hold - HW'(1);

   // Latch bytes carry their own target; data bytes reuse the stored latch
   assign is_latch = wr.wr_data[7];
   assign tgt_ch   = is_latch ? wr.wr_data[6:5] : lch;
   assign tgt_vol  = is_latch ? wr.wr_data[4]   : ltype;
   assign tone_we  = accept && !tgt_vol && (tgt_ch != 2'd3);
   assign noise_we = accept && !tgt_vol && (tgt_ch == 2'd3);

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         vol_r <= {4{4'hF}};
         tone  <= '0;
         noise <= '0;
         lch   <= '0;
         ltype <= 1'b0;
      end else if (accept) begin
         if (is_latch) begin
            lch   <= wr.wr_data[6:5];
            ltype <= wr.wr_data[4];
         end
         if (tgt_vol) vol_r[tgt_ch] <= wr.wr_data[3:0];
         for (int n = 0; n < 3; n++)
            if (tone_we && tgt_ch == 2'(n)) begin
               if (is_latch) tone[n][3:0] <= wr.wr_data[3:0];
               else          tone[n][9:4] <= wr.wr_data[5:0];
            end
         if (noise_we) noise <= wr.wr_data[2:0];
      end

   // Tone counters read the pre-write tone value, so a same-edge write never affects this reload
   ti_psg_tone u_tone [2:0] (
      .CLK    (CLK),
      .nRST   (nRST),
      .tick   (tick),
      .period (tone),
      .out    (ch_out)
   );

   always_comb begin
      case (noise[1:0])
         2'b00:   nper = 10'd15;
         2'b01:   nper = 10'd31;
         default: nper = 10'd63;
      endcase
      nff_next  = nff;
      ncnt_next = ncnt;
      if (noise[1:0] == 2'b11) begin
         nff_next = ch_out[2];
      end else if (tick) begin
         if (ncnt == '0) begin
            ncnt_next = nper;
            nff_next  = ~nff;
         end else begin
            ncnt_next = ncnt - 10'd1;
         end
      end
      if (noise_we) ncnt_next = '0;
   end

   assign shift = ~nff & nff_next;
   assign fb    = noise[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0];

   // A noise write restarts the generator and overrides a coincident shift
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         nff  <= 1'b0;
         ncnt <= '0;
         lfsr <= LFSR_RST;
      end else begin
         nff  <= nff_next;
         ncnt <= ncnt_next;
         if (noise_we)   lfsr <= LFSR_RST;
         else if (shift) lfsr <= {fb, lfsr[LFSR_W-1:1]};
      end

   assign vol0   = vol_r[0];
   assign vol1   = vol_r[1];
   assign vol2   = vol_r[2];
   assign vol3   = vol_r[3];
   assign ch0out = ch_out[0];
   assign ch1out = ch_out[1];
   assign ch2out = ch_out[2];
   assign ch3out = lfsr[0];
endmodule

// File: tb/tb_ti_psg_ctrl.sv
// Scoreboard bench for ti_psg_ctrl: reference model pushes per-cycle expectations, monitor compares.
module tb_ti_psg_ctrl;
   localparam int DIV = 16, WR_HOLD = 2, LW = 16;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic [3:0] vol0, vol1, vol2, vol3;
   logic ch0out, ch1out, ch2out, ch3out;

   ti_psg_ctrl_if wr ();

   ti_psg_ctrl #(.DIV(DIV), .WR_HOLD(WR_HOLD), .LFSR_W(LW)) dut (
      .CLK(CLK), .nRST(nRST), .wr(wr),
      .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
      .ch0out(ch0out), .ch1out(ch1out), .ch2out(ch2out), .ch3out(ch3out)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        rdy;
      logic [15:0] vol;
      logic [3:0]  ch;
   } obs_t;

   obs_t sbq[$];
   int n_tests = 0, n_fail = 0;

   // Reference model state
   int m_vol[4], m_tone[3], m_tcnt[3];
   bit m_tout[3];
   int m_noise, m_lch, m_ncnt, m_pre, m_hold;
   bit m_lvol, m_nff;
   logic [15:0] m_lfsr;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_vol[i] = 15;
      for (int i = 0; i < 3; i++) begin m_tone[i] = 0; m_tcnt[i] = 0; m_tout[i] = 0; end
      m_noise = 0; m_lch = 0; m_lvol = 0; m_ncnt = 0; m_pre = 0; m_hold = 0;
      m_nff = 0; m_lfsr = 16'h8000;
   endtask

   task automatic noise_write(input int v);
      m_noise = v; m_lfsr = 16'h8000; m_ncnt = 0;
   endtask

   task automatic apply_write(input logic [7:0] d);
      if (d[7]) begin
         m_lch = int'(d[6:5]); m_lvol = d[4];
         if (m_lvol)         m_vol[m_lch] = int'(d[3:0]);
         else if (m_lch < 3) m_tone[m_lch] = (m_tone[m_lch] & 'h3F0) | int'(d[3:0]);
         else                noise_write(int'(d[2:0]));
      end else begin
         if (m_lvol)         m_vol[m_lch] = int'(d[3:0]);
         else if (m_lch < 3) m_tone[m_lch] = (m_tone[m_lch] & 'h00F) | (int'(d[5:0]) << 4);
         else                noise_write(int'(d[2:0]));
      end
   endtask

   // One clock of the spec's rules: counters see the register values from before this edge's write
   task automatic model_step(input bit v, input logic [7:0] d);
      bit tick, acc, ch2_old, nxt, fb;
      tick = (m_pre == DIV - 1);
      m_pre = tick ? 0 : m_pre + 1;
      acc = v && (m_hold == 0);
      m_hold = acc ? WR_HOLD : (m_hold > 0 ? m_hold - 1 : 0);
      ch2_old = m_tout[2];
      if (tick)
         for (int n = 0; n < 3; n++) begin
            if (m_tone[n] < 2)      begin m_tout[n] = 1; m_tcnt[n] = 0; end
            else if (m_tcnt[n] > 0) m_tcnt[n]--;
            else begin m_tcnt[n] = m_tone[n] - 1; m_tout[n] = !m_tout[n]; end
         end
      nxt = m_nff;
      if ((m_noise & 3) == 3) nxt = ch2_old;
      else if (tick) begin
         if (m_ncnt == 0) begin m_ncnt = (16 << (m_noise & 3)) - 1; nxt = !m_nff; end
         else m_ncnt--;
      end
      if (!m_nff && nxt) begin
         fb = (m_noise & 4) ? (m_lfsr[0] ^ m_lfsr[3]) : m_lfsr[0];
         m_lfsr = {fb, m_lfsr[15:1]};
      end
      m_nff = nxt;
      if (acc) apply_write(d);
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.rdy = (m_hold == 0);
      o.vol = {4'(m_vol[3]), 4'(m_vol[2]), 4'(m_vol[1]), 4'(m_vol[0])};
      o.ch  = {m_lfsr[0], m_tout[2], m_tout[1], m_tout[0]};
      return o;
   endfunction

   initial forever begin
      @(posedge CLK);
      if (nRST) begin
         model_step(wr.wr_valid, wr.wr_data);
         sbq.push_back(model_obs());
      end
   end

   // Monitor
   initial forever begin
      obs_t e, a;
      @(negedge CLK);
      if (nRST && sbq.size() > 0) begin
         e = sbq.pop_front();
         a = {wr.wr_ready, vol3, vol2, vol1, vol0, ch3out, ch2out, ch1out, ch0out};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t got rdy=%b vol=%h ch=%b expected rdy=%b vol=%h ch=%b",
                     $time, a.rdy, a.vol, a.ch, e.rdy, e.vol, e.ch);
         end
         if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sbq_depth got %0d expected 0", sbq.size());
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr_byte(input logic [7:0] b);
      int k = 0;
      while (!wr.wr_ready && k < 20) begin @(negedge CLK); k++; end
      if (!wr.wr_ready) chk("wr_ready_timeout", 0, 1);
      wr.wr_valid = 1'b1; wr.wr_data = b;
      @(negedge CLK);
      wr.wr_valid = 1'b0;
   endtask

   task automatic ch0_gap(output int cyc);
      logic p;
      p = ch0out; cyc = 0;
      while (ch0out === p && cyc < 6000) begin @(negedge CLK); cyc++; end
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 0) b[5:2] = 4'b0000;
      return b;
   endfunction

   initial begin
      int g, hi;
      wr.wr_valid = 1'b0; wr.wr_data = 8'h00;
      model_reset();
      repeat (3) @(negedge CLK);
      chk("rst_vol", {vol3, vol2, vol1, vol0}, 16'hFFFF);
      chk("rst_ch", {ch3out, ch2out, ch1out, ch0out}, 0);
      chk("rst_ready", wr.wr_ready, 1);
      nRST = 1'b1;
      @(negedge CLK);

      // Volume write, hold window, dropped pulse, latched data byte
      wr_byte(8'hD5);
      chk("vol2_latch", vol2, 5);
      chk("hold_c1", wr.wr_ready, 0);
      @(negedge CLK);
      chk("hold_c2", wr.wr_ready, 0);
      wr.wr_valid = 1'b1; wr.wr_data = 8'hD9;
      @(negedge CLK);
      wr.wr_valid = 1'b0;
      chk("hold_drop_vol2", vol2, 5);
      chk("hold_end", wr.wr_ready, 1);
      wr_byte(8'h03);
      chk("vol2_data", vol2, 3);

      // tone0 = 0x0FE: half period 254 ticks
      wr_byte(8'h8E); wr_byte(8'h0F);
      ch0_gap(g);
      ch0_gap(g); chk("tone0_gap1", g, 254 * DIV);
      ch0_gap(g); chk("tone0_gap2", g, 254 * DIV);

      // tone1 = 1: output held high
      wr_byte(8'hA1); wr_byte(8'h00);
      for (int i = 0; i < 3; i++) begin
         repeat (100) @(negedge CLK);
         chk("tone1_stuck", ch1out, 1);
      end

      // Periodic noise: one shift period of 1 per sixteen shifts
      wr_byte(8'hE0);
      chk("lfsr_reload", ch3out, 0);
      hi = 0;
      for (int i = 0; i < 16 * 32 * DIV; i++) begin @(negedge CLK); hi += ch3out; end
      chk("periodic_high_cycles", hi, 32 * DIV);

      // White noise and rate 11 driven from tone2 = 0x010
      wr_byte(8'hE4);
      repeat (20 * 32 * DIV + 600) @(negedge CLK);
      wr_byte(8'hE3); wr_byte(8'hC0); wr_byte(8'h01);
      repeat (3000) @(negedge CLK);

      // Dense writes land on tick and shift edges
      repeat (40) wr_byte(8'hE1);
      repeat (30) wr_byte({1'b1, 2'($urandom_range(0, 2)), 1'b0, 4'($urandom)});
      for (int i = 0; i < 700; i++) begin
         repeat ($urandom_range(0, 20)) @(negedge CLK);
         wr_byte(rand_byte());
      end

      // Asynchronous reset mid-stream
      wr_byte(8'hD7);
      #3 nRST = 1'b0;
      model_reset();
      sbq.delete();
      #1;
      chk("arst_vol", {vol3, vol2, vol1, vol0}, 16'hFFFF);
      chk("arst_ch", {ch3out, ch2out, ch1out, ch0out}, 0);
      chk("arst_ready", wr.wr_ready, 1);
      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 10)) @(negedge CLK);
         wr_byte(rand_byte());
      end
      repeat (4) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
